// File: rtl/muntjac_fpu_pkg.sv
// Shared FPU types: rounding modes, exception flags, value classes and
// the canonical NaN encoding used by every pack/convert unit.
package muntjac_fpu_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rounding_mode_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    typedef enum logic [1:0] {
        CLASS_FINITE,
        CLASS_ZERO,
        CLASS_INF,
        CLASS_NAN
    } value_class_e;

    localparam int MaxFloatWidth = 64;

    // Quiet NaN with positive sign and only the top fraction bit set,
    // right-aligned in a MaxFloatWidth vector.
    function automatic logic [MaxFloatWidth-1:0] canonical_nan(input int exp_width,
                                                               input int sig_width);
        logic [MaxFloatWidth-1:0] exp_ones;
        logic [MaxFloatWidth-1:0] quiet_bit;
        exp_ones  = ((MaxFloatWidth'(1) << exp_width) - MaxFloatWidth'(1)) << sig_width;
        quiet_bit = MaxFloatWidth'(1) << (sig_width - 1);
        return exp_ones | quiet_bit;
    endfunction

endpackage

// File: rtl/muntjac_fpu_right_shift.sv
// Logical right shift that also reports whether any set bit fell off the
// bottom; shifts of DataWidth or more clear the data and gather everything.
module muntjac_fpu_right_shift #(
    parameter int DataWidth  = 8,
    parameter int ShiftWidth = 4
) (
    input  logic [DataWidth-1:0]  data_i,
    input  logic [ShiftWidth-1:0] shift_i,
    output logic [DataWidth-1:0]  data_o,
    output logic                  sticky_o
);

    logic [DataWidth-1:0] lost_mask;

    assign lost_mask = ~({DataWidth{1'b1}} << shift_i);
    assign data_o    = data_i >> shift_i;
    assign sticky_o  = |(data_i & lost_mask);

endmodule

// File: rtl/muntjac_fpu_round_increment.sv
// Rounding decision shared by float packing and int conversion: whether to
// add one ulp, and whether the discarded bits make the result inexact.
module muntjac_fpu_round_increment import muntjac_fpu_pkg::*; (
    input  rounding_mode_e rounding_mode_i,
    input  logic           sign_i,
    input  logic           lsb_i,
    input  logic           guard_i,
    input  logic           sticky_i,
    output logic           increment_o,
    output logic           inexact_o
);

    assign inexact_o = guard_i | sticky_i;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any branch, so no path can leave it unassigned and infer a latch.
        increment_o = 1'b0;
        case (rounding_mode_i)
            RTZ:     increment_o = 1'b0;
            RDN:     increment_o = sign_i & (guard_i | sticky_i);
            RUP:     increment_o = ~sign_i & (guard_i | sticky_i);
            RMM:     increment_o = guard_i;
            default: increment_o = guard_i & (sticky_i | lsb_i);
        endcase
    end

endmodule

// File: rtl/muntjac_fpu_round_pack.sv
// Two-stage round-and-pack: aligns the unrounded internal result (stage 1),
// then rounds, detects overflow/underflow and packs IEEE-754 bits (stage 2).
module muntjac_fpu_round_pack import muntjac_fpu_pkg::*; #(
    parameter int  ExpWidth   = 8,
    parameter int  SigWidth   = 23,
    parameter int  InExpWidth = 10,
    localparam int InSigWidth = SigWidth + 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  rounding_mode_e               rounding_mode_i,
    input  logic                         in_sign_i,
    input  logic signed [InExpWidth-1:0] in_exponent_i,
    input  logic [InSigWidth-1:0]        in_significand_i,
    input  logic                         in_is_zero_i,
    input  logic                         in_is_inf_i,
    input  logic                         in_is_nan_i,
    input  logic                         in_invalid_i,
    input  logic                         in_div_by_zero_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [ExpWidth+SigWidth:0]   out_data_o,
    output logic [4:0]                   out_flags_o
);

    localparam int DataWidth   = ExpWidth + SigWidth + 1;
    localparam int MagWidth    = ExpWidth + SigWidth;
    localparam int BiasedWidth = InExpWidth + 1;
    localparam int Bias        = 2 ** (ExpWidth - 1) - 1;
    localparam int ExpMax      = 2 ** ExpWidth - 1;
    localparam int AlignWidth  = SigWidth + 3;
    localparam int ShiftMax    = SigWidth + 3;
    localparam int ShiftWidth  = $clog2(ShiftMax + 1);

    localparam logic signed [BiasedWidth-1:0] BiasedZero     = '0;
    localparam logic signed [BiasedWidth-1:0] BiasedOne      = BiasedWidth'(1);
    localparam logic signed [BiasedWidth-1:0] BiasedBias     = BiasedWidth'(Bias);
    localparam logic signed [BiasedWidth-1:0] BiasedOverflow = BiasedWidth'(ExpMax);
    localparam logic signed [BiasedWidth-1:0] BiasedShiftMax = BiasedWidth'(ShiftMax);
    localparam logic [DataWidth-1:0]          CanonicalNan   =
        DataWidth'(canonical_nan(ExpWidth, SigWidth));

    typedef struct packed {
        logic                sign;
        rounding_mode_e      rm;
        logic [ExpWidth-1:0] exp;
        logic [SigWidth-1:0] frac;
        logic                lsb;
        logic                guard;
        logic                sticky;
        logic                tiny;
        logic                ovf;
        value_class_e        cls;
        logic                nv;
        logic                dz;
    } align_t;

    // ---------------------------------------------------------------- handshake
    logic s1_valid;
    logic s2_valid;
    logic advance2;

    assign advance2    = !s2_valid || out_ready_i;
    assign in_ready_o  = !s1_valid || advance2;
    assign out_valid_o = s2_valid;

    // ---------------------------------------------------------------- stage 1
    logic signed [BiasedWidth-1:0] biased;
    logic signed [BiasedWidth-1:0] shift_full;
    logic [ShiftWidth-1:0]         shift_amt;
    logic                          subnormal;
    logic [AlignWidth-1:0]         aligned;
    logic                          shift_sticky;
    logic                          unused_align_msb;
    logic                          frac_all_ones;
    logic                          full_inc;
    logic                          unused_full_nx;
    align_t                        s1_d;
    align_t                        s1_q;

    assign biased     = $signed({in_exponent_i[InExpWidth-1], in_exponent_i}) + BiasedBias;
    assign shift_full = BiasedOne - biased;
    assign subnormal  = biased <= BiasedZero;
    assign shift_amt  = !subnormal                   ? '0 :
                        (shift_full > BiasedShiftMax) ? ShiftWidth'(ShiftMax) :
                                                        shift_full[ShiftWidth-1:0];

    muntjac_fpu_right_shift #(
        .DataWidth  (AlignWidth),
        .ShiftWidth (ShiftWidth)
    ) u_denorm_shift (
        .data_i   ({1'b1, in_significand_i}),
        .shift_i  (shift_amt),
        .data_o   (aligned),
        .sticky_o (shift_sticky)
    );

    // A shift of at least one always clears the top bit.
    assign unused_align_msb = aligned[AlignWidth-1];

    // Tininess after rounding: at biased == 0 the value is tiny unless
    // rounding 1.frac at full normal precision would carry into 2^emin.
    assign frac_all_ones = &in_significand_i[InSigWidth-1:2];

    muntjac_fpu_round_increment u_tiny_round (
        .rounding_mode_i (rounding_mode_i),
        .sign_i          (in_sign_i),
        .lsb_i           (in_significand_i[2]),
        .guard_i         (in_significand_i[1]),
        .sticky_i        (in_significand_i[0]),
        .increment_o     (full_inc),
        .inexact_o       (unused_full_nx)
    );

    always_comb begin
        s1_d      = '0;
        s1_d.sign = in_sign_i;
        s1_d.rm   = rounding_mode_i;
        s1_d.nv   = in_invalid_i;
        s1_d.dz   = in_div_by_zero_i;
        s1_d.ovf  = biased >= BiasedOverflow;
        s1_d.tiny = (biased < BiasedZero) ||
                    ((biased == BiasedZero) && !(frac_all_ones && full_inc));

        if (in_is_nan_i)       s1_d.cls = CLASS_NAN;
        else if (in_is_inf_i)  s1_d.cls = CLASS_INF;
        else if (in_is_zero_i) s1_d.cls = CLASS_ZERO;
        else                   s1_d.cls = CLASS_FINITE;

        if (subnormal) begin
            s1_d.exp    = '0;
            s1_d.frac   = aligned[SigWidth+1:2];
            s1_d.lsb    = aligned[2];
            s1_d.guard  = aligned[1];
            s1_d.sticky = aligned[0] | shift_sticky;
        end else begin
            s1_d.exp    = biased[ExpWidth-1:0];
            s1_d.frac   = in_significand_i[InSigWidth-1:2];
            s1_d.lsb    = in_significand_i[2];
            s1_d.guard  = in_significand_i[1];
            s1_d.sticky = in_significand_i[0];
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic                 round_inc;
    logic                 round_nx;
    logic                 overflow;
    logic                 overflow_to_inf;
    logic [MagWidth-1:0]  mag_rounded;
    logic [DataWidth-1:0] res_data;
    fflags_t              res_flags;
    logic [DataWidth-1:0] out_data_q;
    fflags_t              out_flags_q;

    muntjac_fpu_round_increment u_round (
        .rounding_mode_i (s1_q.rm),
        .sign_i          (s1_q.sign),
        .lsb_i           (s1_q.lsb),
        .guard_i         (s1_q.guard),
        .sticky_i        (s1_q.sticky),
        .increment_o     (round_inc),
        .inexact_o       (round_nx)
    );

    // Adding across the whole {exp, frac} field lets a fraction carry bump
    // the exponent, including subnormal -> smallest normal.
    assign mag_rounded = {s1_q.exp, s1_q.frac} + MagWidth'(round_inc);
    assign overflow    = s1_q.ovf || (&mag_rounded[MagWidth-1:SigWidth]);

    always_comb begin
        overflow_to_inf = 1'b1;
        case (s1_q.rm)
            RTZ:     overflow_to_inf = 1'b0;
            RDN:     overflow_to_inf = s1_q.sign;
            RUP:     overflow_to_inf = ~s1_q.sign;
            default: overflow_to_inf = 1'b1;
        endcase
    end

    always_comb begin
        res_data     = '0;
        res_flags    = '0;
        res_flags.nv = s1_q.nv;
        res_flags.dz = s1_q.dz;
        case (s1_q.cls)
            CLASS_NAN:  res_data = CanonicalNan;
            CLASS_INF:  res_data = {s1_q.sign, {ExpWidth{1'b1}}, {SigWidth{1'b0}}};
            CLASS_ZERO: res_data = {s1_q.sign, {MagWidth{1'b0}}};
            default: begin
                if (overflow) begin
                    res_flags.of = 1'b1;
                    res_flags.nx = 1'b1;
                    res_data     = overflow_to_inf
                        ? {s1_q.sign, {ExpWidth{1'b1}}, {SigWidth{1'b0}}}
                        : {s1_q.sign, {(ExpWidth-1){1'b1}}, 1'b0, {SigWidth{1'b1}}};
                end else begin
                    res_flags.nx = round_nx;
                    res_flags.uf = s1_q.tiny & round_nx;
                    res_data     = {s1_q.sign, mag_rounded};
                end
            end
        endcase
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk_i) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // the pre-edge values, independent of statement order.
        if (!rst_ni) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            out_data_q  <= '0;
            out_flags_q <= '0;
        end else begin
            if (in_ready_o) s1_valid <= in_valid_i;
            if (advance2)   s2_valid <= s1_valid;
            if (advance2 && s1_valid) begin
                out_data_q  <= res_data;
                out_flags_q <= res_flags;
            end
        end
    end

    // NOTE: stage-1 payload has no reset; it is only observed while s1_valid,
    // which is reset, so clearing it would cost reset fan-out for nothing.
    always_ff @(posedge clk_i) begin
        if (in_valid_i && in_ready_o) s1_q <= s1_d;
    end

    assign out_data_o  = out_data_q;
    assign out_flags_o = out_flags_q;

endmodule

// File: doc/muntjac_fpu_round_pack.md
Name: muntjac_fpu_round_pack

Overview:
- Consumer end of the FPU arithmetic datapath: takes the unrounded internal-format result emitted by add/mul/fma units and produces an IEEE-754 encoding plus fflags.
- Internal format is sign, signed unbiased exponent, and fraction below an implicit leading 1 (guard and sticky at the bottom), plus zero/inf/nan/invalid flags.
- Two-stage valid/ready pipeline placed between the arithmetic unit and FP register-file writeback.

Parameters:
- ExpWidth, 8, IEEE exponent field width of the output format.
- SigWidth, 23, IEEE fraction field width of the output format.
- InExpWidth, 10, width of the signed unbiased input exponent.
- Localparam InSigWidth = SigWidth+2: the input significand is {fraction[SigWidth], guard, sticky}.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  block can accept a beat.
- rounding_mode_i  in  muntjac_fpu_pkg::rounding_mode_e  rounding mode, captured with the beat.
- in_sign_i  in  1  result sign.
- in_exponent_i  in  InExpWidth (signed)  unbiased exponent; value = 1.sig * 2^exp.
- in_significand_i  in  InSigWidth  fraction, guard and sticky.
- in_is_zero_i, in_is_inf_i, in_is_nan_i  in  1 each  special-value class.
- in_invalid_i  in  1  NV raised upstream.
- in_div_by_zero_i  in  1  DZ raised upstream.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts the result.
- out_data_o  out  ExpWidth+SigWidth+1  packed IEEE value {sign, exp, frac}.
- out_flags_o  out  5  {NV, DZ, OF, UF, NX}, bit 4 down to bit 0.

Behaviour:
- Reset: s1_valid and s2_valid are cleared, so out_valid_o=0 and in_ready_o=1 in the cycle after rst_ni is sampled low. out_data_o and out_flags_o reset to 0. A beat in flight is discarded.
- Handshake:
  - A transfer occurs when valid && ready.
  - advance2 = !s2_valid || out_ready_i.
  - in_ready_o = !s1_valid || advance2 (combinational, no bubble).
  - Once asserted, out_valid_o and its data stay stable until accepted.
- Latency: 2 cycles from input acceptance to out_valid_o when unstalled. Throughput is 1 beat per cycle. The pipeline holds at most 2 beats.
- Stage 1, align:
  - biased = in_exponent_i + (2^(ExpWidth-1)-1), computed at InExpWidth+1 bits signed.
  - If biased <= 0 (subnormal): shift {1, significand} right by 1-biased, saturating at SigWidth+3. All shifted-out bits OR into sticky. Exponent field = 0.
  - Otherwise: exponent field = biased and the implicit 1 is dropped.
  - Register the following: sign, rounding mode, field candidate, lsb, guard, sticky, tiny-before-round, special class, NV, DZ.
- Stage 2, round and pack:
  - Round increment inc per mode:
    - RNE: g&(s|lsb).
    - RTZ: 0.
    - RDN: sign&(g|s).
    - RUP: !sign&(g|s).
    - RMM: g.
    - Reserved encodings: treated as RNE.
  - {exp, frac} += inc. A carry out of the fraction bumps the exponent; a subnormal rounding to 2^emin becomes normal.
  - NX = g|s.
  - Overflow when biased >= 2^ExpWidth-1 before rounding, or exp becomes all-ones after rounding.
    - Set OF and NX.
    - Result is inf for RNE, RMM, RUP&!sign, or RDN&sign. Otherwise it is max finite (exp = all-ones-1, frac = all ones).
  - Tininess is detected after rounding. Tiny when biased < 0, or when biased == 0 and rounding 1.frac at full precision does not carry out.
  - UF = tiny & NX.
- Specials bypass rounding and set no OF/UF/NX:
  - NaN: canonical {0, all ones, 1000...0}.
  - Inf: {sign, all ones, 0}.
  - Zero: {sign, 0, 0}.
  - Priority is nan > inf > zero.
- NV and DZ pass through unchanged in all cases.

Decomposition:
- Add to muntjac_fpu_pkg:
  - fflags_t packed struct {nv, dz, of, uf, nx}.
  - Helper function canonical_nan(ExpWidth, SigWidth).
- Reuse existing rounding_mode_e and muntjac_fpu_right_shift for the subnormal shift.
- One sub-module, muntjac_fpu_round_increment: combinational inc/NX from mode, sign, lsb, g, s. It is shared later with int conversion.

Test Plan:
- exp=0, sig=0, RNE -> 0x3F800000, flags 0x00, out_valid exactly 2 cycles after accept.
- exp=0, frac=all ones, g=1, s=0, RNE -> 0x40000000, flags 0x01; same with RTZ -> 0x3FFFFFFF, flags 0x01.
- exp=128, RNE -> 0x7F800000, flags 0x05; RTZ -> 0x7F7FFFFF, flags 0x05; sign=1 with RUP -> 0xFF7FFFFF.
- Subnormals:
  - exp=-127, sig=0 -> 0x00400000, flags 0x00.
  - exp=-150, sig=0: RNE -> 0x00000000, flags 0x03; RUP -> 0x00000001, flags 0x03.
- Specials:
  - is_nan with invalid=1 -> 0x7FC00000, flags 0x10.
  - is_inf, sign=1 -> 0xFF800000, flags 0x00.
  - is_zero, sign=1, div_by_zero=1 -> 0x80000000, flags 0x08.
- Backpressure and reset:
  - out_ready_i=0 while offering 3 beats: 2 accepted, then in_ready_o=0, out_data_o stable. Release: results emerge in order, 1 per cycle.
  - rst_ni low mid-stall: out_valid_o=0 the next cycle, and no stale beat appears afterwards.
